// File: rtl/alu_funct_pkg.sv
// Shared ALU funct encodings, HI/LO divider FSM state encoding and iteration count.
// Imported by the ALU result mux and by hilo_divider.
package alu_funct_pkg;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor when it fits.
// Latency: combinational. Backpressure: none.
// Flow: pure function of its inputs, no handshake.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // The extra top bit keeps the comparison exact; the difference always fits in WIDTH bits.
    assign shifted = {rem, quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, divisor};
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign rem_n   = ge ? diff : shifted[WIDTH-1:0];
    assign quo_n   = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/hilo_divider.sv
// Multicycle unsigned DIVU with HI (remainder) / LO (quotient) registers; optional DIVZERO_DETECT_EN.
// Latency: 32 cycles accept-to-done (1 cycle for a zero divisor when DIVZERO_DETECT_EN is defined).
// Backpressure: start is ignored while busy; no queueing, a new start is accepted in the done cycle.
module hilo_divider
    import alu_funct_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             busy,
`ifdef DIVZERO_DETECT_EN
    output logic             div_zero,
`endif
    output logic             done
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic             accept;
`ifdef DIVZERO_DETECT_EN
    logic             dz_pend;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvs),
        .rem_n   (rem_n),
        .quo_n   (quo_n)
    );

    assign accept = start && (Signal == F_DIVU) && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == FIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            HiOut <= '0;
            LoOut <= '0;
`ifdef DIVZERO_DETECT_EN
            dz_pend  <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (accept) begin
                        quo   <= dataA;
                        dvs   <= dataB;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= RUN;
`ifdef DIVZERO_DETECT_EN
                        dz_pend <= (dataB == '0);
                        if (dataB != '0)
                            div_zero <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
`ifdef DIVZERO_DETECT_EN
                    // Zero divisor short-cut: quo still holds the dividend.
                    if (dz_pend) begin
                        HiOut    <= quo;
                        LoOut    <= '1;
                        div_zero <= 1'b1;
                        dz_pend  <= 1'b0;
                        state    <= FIN;
                    end else
`endif
                    begin
                        rem <= rem_n;
                        quo <= quo_n;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            HiOut <= rem_n;
                            LoOut <= quo_n;
                            state <= FIN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
